// File: rtl/compadder_sched_if.sv
// Request/result bundle between the two clients and the compound-adder scheduler.
interface compadder_sched_if #(
  parameter int N      = 4,
  parameter int CHUNKS = 4
);
  localparam int W = N * CHUNKS;

  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1;
  logic         busy, done, done_id;
  logic [W:0]   sum;

  modport master (
    output req0, req1, a0, b0, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, sum
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    output gnt0, gnt1, busy, done, done_id, sum
  );
endinterface

// File: rtl/compadder_sched.sv
// Two-client round-robin scheduler that runs W-bit adds through one N-bit
// compound adder, one chunk per cycle, LSB chunk first.

// Compound adder: s = a+b, t = a+b+1, both with carry-out in the MSB.
module Compadder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   s,
  output logic [N:0]   t
);
  assign s = {1'b0, a} + {1'b0, b};
  assign t = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, 1'b1};
endmodule

module compadder_sched #(
  parameter int N      = 4,
  parameter int CHUNKS = 4
) (
  input  logic                clk,
  input  logic                reset,
  compadder_sched_if.slave    bus
);
  localparam int W     = N * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_sh, b_sh;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             gnt0_r, gnt1_r, done_id_r;
  logic [W:0]       sum_r;

  logic             any_req, win1, last_chunk;
  logic [N:0]       s, t;
  logic [N-1:0]     res;
  logic             cy;

  assign any_req    = bus.req0 | bus.req1;
  // On a tie the client that was not served last wins.
  assign win1       = bus.req1 & (~bus.req0 | ~last);
  assign last_chunk = (idx == IDX_W'(CHUNKS - 1));

  // Operands are kept in shift registers so the active chunk always sits in
  // the low N bits; equivalent to indexing A[idx*N +: N] without a wide mux.
  Compadder #(.N(N)) u_add (
    .a (a_sh[N-1:0]),
    .b (b_sh[N-1:0]),
    .s (s),
    .t (t)
  );

  // Carry-select: the registered carry picks the precomputed +0 or +1 sum.
  always_comb begin
    {cy, res} = carry ? t : s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture on grant, chunk-wise sum build-up in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      last      <= 1'b1;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      done_id_r <= 1'b0;
      sum_r     <= '0;
    end else begin
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            a_sh      <= win1 ? bus.a1 : bus.a0;
            b_sh      <= win1 ? bus.b1 : bus.b0;
            carry     <= 1'b0;
            idx       <= '0;
            last      <= win1;
            done_id_r <= win1;
            gnt0_r    <= ~win1;
            gnt1_r    <= win1;
          end
        end
        RUN: begin
          sum_r[idx*N +: N] <= res;
          carry             <= cy;
          a_sh              <= a_sh >> N;
          b_sh              <= b_sh >> N;
          if (last_chunk) begin
            sum_r[W] <= cy;
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_r;
  assign bus.gnt1    = gnt1_r;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.done_id = done_id_r;
  assign bus.sum     = sum_r;
endmodule

// File: tb/tb_compadder_sched.sv
// Bench for compadder_sched: directed scenarios plus a random soak, all
// checked against a cycle-count/arithmetic reference model.
module tb_compadder_sched;
  localparam int N      = 4;
  localparam int CHUNKS = 4;
  localparam int W      = N * CHUNKS;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  compadder_sched_if #(.N(N), .CHUNKS(CHUNKS)) bus ();

  compadder_sched #(.N(N), .CHUNKS(CHUNKS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: an operation occupies the block for CHUNKS+1 cycles after
  // the grant edge; done is the last of them; result is plain a+b.
  int         m_cnt  = 0;
  bit         m_last = 1'b1;
  bit         armed  = 1'b0;
  bit         m_w;
  bit         e_g0, e_g1, e_done, e_busy, e_rst, e_id;
  logic [W:0] e_sum;
  int         n_done = 0;

  // Compare this cycle, then predict the cycle after the coming edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("gnt0", bus.gnt0, e_g0);
      chk("gnt1", bus.gnt1, e_g1);
      chk("done", bus.done, e_done);
      chk("busy", bus.busy, e_busy);
      if (e_done) begin
        chk("sum", bus.sum, e_sum);
        chk("done_id", bus.done_id, e_id);
      end
      if (e_rst) begin
        chk("rst_sum", bus.sum, '0);
        chk("rst_done_id", bus.done_id, 0);
      end
    end
    if (bus.done === 1'b1) n_done++;
    e_g0 = 0; e_g1 = 0; e_done = 0; e_rst = 0;
    if (reset) begin
      armed  = 1'b1;
      m_cnt  = 0;
      m_last = 1'b1;
      e_rst  = 1'b1;
    end else if (m_cnt == 0) begin
      if (bus.req0 || bus.req1) begin
        m_w    = bus.req1 && (!bus.req0 || !m_last);
        e_sum  = m_w ? ({1'b0, bus.a1} + {1'b0, bus.b1}) : ({1'b0, bus.a0} + {1'b0, bus.b0});
        e_id   = m_w;
        m_last = m_w;
        e_g0   = !m_w;
        e_g1   = m_w;
        m_cnt  = CHUNKS + 1;
      end
    end else begin
      m_cnt--;
      e_done = (m_cnt == 1);
    end
    e_busy = (m_cnt > 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_op();
    int p;
    p = $urandom_range(0, 7);
    if (p == 0) return '1;
    if (p == 1) return '0;
    return W'($urandom);
  endfunction

  // One single-client operation with explicit latency and result checks.
  task automatic do_op(input bit c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] exp, input string tag);
    int  k;
    bit  got;
    if (c) begin bus.req1 = 1; bus.a1 = a; bus.b1 = b; end
    else   begin bus.req0 = 1; bus.a0 = a; bus.b0 = b; end
    got = 0;
    for (k = 0; k < 20 && !got; k++) begin
      step();
      if (c ? bus.gnt1 : bus.gnt0) got = 1;
    end
    chk({tag, "_gnt"}, got, 1);
    bus.req0 = 0;
    bus.req1 = 0;
    k = 0;
    got = 0;
    while (k < 20 && !got) begin
      if (bus.done) got = 1;
      else begin step(); k++; end
    end
    chk({tag, "_lat"}, k, CHUNKS);
    chk({tag, "_sum"}, bus.sum, exp);
    chk({tag, "_id"}, bus.done_id, c);
    step();
  endtask

  initial begin
    int k;
    int g1_lat;
    int seq[$];
    int soak_start;
    bit r0_prev, r1_prev;

    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_sum", bus.sum, '0);

    // Directed arithmetic cases.
    do_op(0, 16'h0FFF, 16'h0001, 17'h01000, "single");
    do_op(1, 16'hFFFF, 16'h0001, 17'h10000, "ripple");
    do_op(0, 16'hFFFF, 16'hFFFF, 17'h1FFFE, "max");

    // Tie right after reset: client 0 first, client 1 at the next IDLE.
    do_reset();
    bus.a0 = 16'h1111; bus.b0 = 16'h2222; bus.a1 = 16'h8000; bus.b1 = 16'h8001;
    bus.req0 = 1; bus.req1 = 1;
    k = 0;
    while (k < 20 && !(bus.gnt0 || bus.gnt1)) begin step(); k++; end
    chk("tie_first_gnt0", bus.gnt0, 1);
    chk("tie_first_gnt1", bus.gnt1, 0);
    bus.req0 = 0;
    g1_lat = 0;
    while (g1_lat < 20 && !bus.gnt1) begin step(); g1_lat++; end
    chk("tie_gnt1_gap", g1_lat, CHUNKS + 2);
    bus.req1 = 0;
    repeat (CHUNKS + 3) step();

    // Round robin with both requests held permanently.
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    k = 0;
    while (k < 200 && seq.size() < 6) begin
      step();
      k++;
      if (bus.gnt0) seq.push_back(0);
      if (bus.gnt1) seq.push_back(1);
    end
    chk("rr_count", seq.size(), 6);
    foreach (seq[i]) chk("rr_order", seq[i], i % 2);
    bus.req0 = 0; bus.req1 = 0;
    repeat (CHUNKS + 3) step();

    // Reset in RUN aborts cleanly.
    bus.a0 = 16'h1234; bus.b0 = 16'h1111;
    bus.req0 = 1;
    k = 0;
    while (k < 20 && !bus.gnt0) begin step(); k++; end
    chk("abort_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_sum", bus.sum, '0);
    for (int i = 0; i < CHUNKS + 2; i++) begin
      chk("abort_no_done", bus.done, 0);
      step();
    end
    do_op(1, 16'h00F0, 16'h0F10, 17'h01000, "after_abort");
    bus.a0 = 16'h0003; bus.b0 = 16'h0004; bus.a1 = 16'h0005; bus.b1 = 16'h0006;
    bus.req0 = 1; bus.req1 = 1;
    k = 0;
    while (k < 20 && !(bus.gnt0 || bus.gnt1)) begin step(); k++; end
    chk("abort_tie_gnt0", bus.gnt0, 1);
    bus.req0 = 0; bus.req1 = 0;
    repeat (CHUNKS + 3) step();

    // Random soak: independent clients with random request patterns.
    soak_start = n_done;
    k = 0;
    while (k < 60000 && (n_done - soak_start) < 1000) begin
      r0_prev = bus.req0;
      r1_prev = bus.req1;
      if (!r0_prev) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.req0 = 1; bus.a0 = rnd_op(); bus.b0 = rnd_op();
        end
      end else if (bus.gnt0) begin
        if ($urandom_range(0, 3) == 0) begin bus.a0 = rnd_op(); bus.b0 = rnd_op(); end
        else bus.req0 = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        bus.req0 = 0;
      end
      if (!r1_prev) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.req1 = 1; bus.a1 = rnd_op(); bus.b1 = rnd_op();
        end
      end else if (bus.gnt1) begin
        if ($urandom_range(0, 3) == 0) begin bus.a1 = rnd_op(); bus.b1 = rnd_op(); end
        else bus.req1 = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        bus.req1 = 0;
      end
      step();
      k++;
    end
    chk("soak_ops_done", (n_done - soak_start) >= 1000, 1);
    bus.req0 = 0; bus.req1 = 0;
    repeat (CHUNKS + 4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
